// File: rtl/frame_eq_compare.sv
// frame_eq_compare: streaming frame comparator.
// Consumes pairs of WIDTH-bit words over a valid/ready stream. A frame ends
// on a beat with in_last set. Each frame produces one registered result:
// equal/gt/lt, the index of the first differing word, and an overflow flag.
// For the magnitude result, word 0 of a frame is the most significant word.
// Optional build macro FRAME_EQ_COMPARE_MASK_EN adds an in_mask port.
// Mask bits set to 1 are ignored for both the equality and the magnitude compare.
module frame_eq_compare #(
  parameter  int WIDTH     = 8,
  parameter  int MAX_BEATS = 16,
  localparam int IDXW      = $clog2(MAX_BEATS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
`ifdef FRAME_EQ_COMPARE_MASK_EN
  input  logic [WIDTH-1:0] in_mask,
`endif
  input  logic            in_last,
  output logic            res_valid,
  input  logic            res_ready,
  output logic            res_equal,
  output logic            res_gt,
  output logic            res_lt,
  output logic [IDXW-1:0] res_idx,
  output logic            res_ovf
);

  localparam logic [IDXW-1:0] CNT_MAX = IDXW'(MAX_BEATS - 1);

  typedef enum logic {ACCUM, RESULT} state_t;

  typedef struct packed {
    logic            equal;
    logic            gt;
    logic            lt;
    logic [IDXW-1:0] idx;
    logic            ovf;
  } res_t;

  state_t          state, state_nx;
  res_t            res_q, res_nx;

  logic [IDXW-1:0] cnt;
  logic            mis;
  logic            gt_q;
  logic [IDXW-1:0] idx_q;
  logic            ovf;

  logic [WIDTH-1:0] mask_w;
  logic [WIDTH-1:0] a_m, b_m;
  logic             beat_fire, res_fire;
  logic             diff, first_mis, at_cap;
  logic             mis_nx, gt_nx;
  logic [IDXW-1:0]  idx_nx;

`ifdef FRAME_EQ_COMPARE_MASK_EN
  assign mask_w = in_mask;
`else
  assign mask_w = '0;
`endif

  // Masked operands feed both the difference detect and the magnitude compare
  assign a_m = in_a & ~mask_w;
  assign b_m = in_b & ~mask_w;

  assign beat_fire = in_valid & in_ready;
  assign res_fire  = res_valid & res_ready;
  assign diff      = |(a_m ^ b_m);
  assign first_mis = beat_fire & diff & ~mis;
  assign at_cap    = (cnt == CNT_MAX);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACCUM;
    else     state <= state_nx;
  end

  // Next-state: a last beat closes the frame, the result handshake reopens it
  always_comb begin
    state_nx = state;
    case (state)
      ACCUM:   if (beat_fire && in_last) state_nx = RESULT;
      RESULT:  if (res_ready)            state_nx = ACCUM;
      default: state_nx = ACCUM;
    endcase
  end

  // Stream handshake outputs are decoded straight from the state
  always_comb begin
    in_ready  = (state == ACCUM);
    res_valid = (state == RESULT);
  end

  // Frame view including the current beat, so a mismatch on the last beat counts
  always_comb begin
    mis_nx = mis | (beat_fire & diff);
    gt_nx  = first_mis ? (a_m > b_m) : gt_q;
    idx_nx = first_mis ? cnt : idx_q;
  end

  // Frame accumulation: beat counter with saturation, first-mismatch capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      mis   <= 1'b0;
      gt_q  <= 1'b0;
      idx_q <= '0;
      ovf   <= 1'b0;
    end else if (res_fire) begin
      cnt   <= '0;
      mis   <= 1'b0;
      gt_q  <= 1'b0;
      idx_q <= '0;
      ovf   <= 1'b0;
    end else if (beat_fire) begin
      if (first_mis) begin
        mis   <= 1'b1;
        gt_q  <= gt_nx;
        idx_q <= idx_nx;
      end
      // Once the counter saturates, further beats report the last index
      // and mark the frame as oversized
      if (!in_last) begin
        if (at_cap) ovf <= 1'b1;
        else        cnt <= cnt + 1'b1;
      end
    end
  end

  // Result encoding: exactly one of equal/gt/lt; idx forced to 0 when equal
  always_comb begin
    res_nx       = res_q;
    res_nx.equal = ~mis_nx;
    res_nx.gt    = mis_nx & gt_nx;
    res_nx.lt    = mis_nx & ~gt_nx;
    res_nx.idx   = mis_nx ? idx_nx : '0;
    res_nx.ovf   = ovf;
  end

  // Result register: loads on the last beat and otherwise holds
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      res_q <= '0;
    else if (beat_fire && in_last) res_q <= res_nx;
  end

  assign res_equal = res_q.equal;
  assign res_gt    = res_q.gt;
  assign res_lt    = res_q.lt;
  assign res_idx   = res_q.idx;
  assign res_ovf   = res_q.ovf;

endmodule
